// File: rtl/wr_ctrl.sv
// Write-burst request controller: ring mode walks base..end, single mode issues one user burst.
// Define WR_FRAME_CNT_EN to add the wr_frame_cnt output (ring wrap counter).
module wr_ctrl #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_BURST_LEN  = 4096,
    parameter int FIFO_CNT_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ddr_init_done,
    input  logic [FIFO_CNT_WIDTH-1:0] wr_fifo_cnt,
    input  logic                      wr_buffer_ready,
    input  logic                      wr_burst_done,
    output logic                      wr_req_en,
    output logic [AXI_ADDR_WIDTH-1:0] wr_addr_out,
    output logic [7:0]                wr_burst_length,
    input  logic                      user_wr_mode,
    input  logic                      user_wr_req,
    input  logic [AXI_ADDR_WIDTH-1:0] user_wr_addr,
    input  logic [12:0]               user_wr_length,
    input  logic [AXI_ADDR_WIDTH-1:0] user_wr_base_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] user_wr_end_addr,
    output logic                      user_wr_busy
`ifdef WR_FRAME_CNT_EN
    ,
    output logic [7:0]                wr_frame_cnt
`endif
);

    localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int BURST_CNT  = AXI_BURST_LEN / BEAT_BYTES;
    localparam int CW         = FIFO_CNT_WIDTH + 14;

    localparam logic [CW-1:0]             BURST_CNT_W = CW'(BURST_CNT);
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(AXI_BURST_LEN);
    localparam logic [12:0]               MAX_LEN     = 13'(AXI_BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_END
    } state_t;

    // NOTE: reset asserts asynchronously but releases through a synchroniser so
    // every flop leaves reset on the same clock edge.
    logic [2:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[1:0], 1'b1};
    end

    assign rst_n_int = rst_sync_q[2];

    logic [2:0] init_sync_q;
    logic [2:0] req_sync_q;
    logic       init_ok;
    logic       req_edge;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            init_sync_q <= '0;
            req_sync_q  <= '0;
        end else begin
            init_sync_q <= {init_sync_q[1:0], ddr_init_done};
            req_sync_q  <= {req_sync_q[1:0], user_wr_req};
        end
    end

    assign init_ok  = init_sync_q[2];
    assign req_edge = req_sync_q[1] & ~req_sync_q[2];

    state_t                      state_q, state_d;
    logic                        req_en_q, req_en_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                        addr_valid_q, addr_valid_d;
    logic [7:0]                  len_q, len_d;
    logic                        mode_q, mode_d;
    logic                        pending_q, pending_d;
    logic [AXI_ADDR_WIDTH-1:0]   cap_addr_q, cap_addr_d;
    logic [12:0]                 cap_len_q, cap_len_d;

    logic [12:0]   len_beats;
    logic [CW-1:0] single_beats;
    logic [CW-1:0] fifo_w;
    logic          handshake;
    logic          ring_wrap;

    // Until the first handshake or single load, the ring start tracks the base input.
    assign wr_addr_out  = addr_valid_q ? addr_q : user_wr_base_addr;
    assign fifo_w       = CW'(wr_fifo_cnt);
    assign handshake    = req_en_q & wr_buffer_ready;
    assign ring_wrap    = (wr_addr_out >= (user_wr_end_addr - BURST_BYTES));
    assign len_beats    = cap_len_q >> BEAT_SHIFT;
    assign single_beats = (cap_len_q > MAX_LEN) ? BURST_CNT_W : CW'(len_beats);

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q      <= S_IDLE;
            req_en_q     <= 1'b0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            len_q        <= '0;
            mode_q       <= 1'b0;
            pending_q    <= 1'b0;
            cap_addr_q   <= '0;
            cap_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            req_en_q     <= req_en_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            len_q        <= len_d;
            mode_q       <= mode_d;
            pending_q    <= pending_d;
            cap_addr_q   <= cap_addr_d;
            cap_len_q    <= cap_len_d;
        end
    end

    // NOTE: every combinational output is given a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        req_en_d     = 1'b0;
        addr_d       = addr_q;
        addr_valid_d = addr_valid_q;
        len_d        = len_q;
        mode_d       = mode_q;
        pending_d    = pending_q;
        cap_addr_d   = cap_addr_q;
        cap_len_d    = cap_len_q;

        case (state_q)
            S_IDLE: begin
                if (!user_wr_mode) begin
                    if (init_ok && (fifo_w >= BURST_CNT_W)) begin
                        state_d = S_REQ;
                        mode_d  = 1'b0;
                        len_d   = 8'(BURST_CNT - 1);
                    end
                end else if (pending_q) begin
                    if (single_beats == '0) begin
                        pending_d = 1'b0;
                    end else if (init_ok && (fifo_w >= single_beats)) begin
                        state_d      = S_REQ;
                        mode_d       = 1'b1;
                        len_d        = 8'(single_beats - CW'(1));
                        addr_d       = cap_addr_q;
                        addr_valid_d = 1'b1;
                        pending_d    = 1'b0;
                    end
                end
            end
            S_REQ: begin
                req_en_d = 1'b1;
                if (handshake) begin
                    req_en_d = 1'b0;
                    state_d  = S_WAIT;
                    if (!mode_q) begin
                        addr_d       = ring_wrap ? user_wr_base_addr : (wr_addr_out + BURST_BYTES);
                        addr_valid_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (wr_burst_done) state_d = S_END;
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new user edge wins over a same-cycle trigger and re-arms the request.
        if (req_edge) begin
            pending_d  = 1'b1;
            cap_addr_d = user_wr_addr;
            cap_len_d  = user_wr_length;
        end
    end

    assign wr_req_en       = req_en_q;
    assign wr_burst_length = len_q;
    assign user_wr_busy    = (state_q != S_IDLE) || pending_q;

`ifdef WR_FRAME_CNT_EN
    logic [7:0] frame_q;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int)                            frame_q <= '0;
        else if (handshake && !mode_q && ring_wrap) frame_q <= frame_q + 8'd1;
    end

    assign wr_frame_cnt = frame_q;
`endif

endmodule

// File: tb/tb_wr_ctrl.sv
// Directed bench for wr_ctrl: a table of single-mode requests plus hand sequences for
// ring walking, handshake stall, init gating and asynchronous reset.
module tb_wr_ctrl;

    logic        clk;
    logic        reset_n;
    logic        ddr_init_done;
    logic [9:0]  wr_fifo_cnt;
    logic        wr_buffer_ready;
    logic        wr_burst_done;
    logic        wr_req_en;
    logic [31:0] wr_addr_out;
    logic [7:0]  wr_burst_length;
    logic        user_wr_mode;
    logic        user_wr_req;
    logic [31:0] user_wr_addr;
    logic [12:0] user_wr_length;
    logic [31:0] user_wr_base_addr;
    logic [31:0] user_wr_end_addr;
    logic        user_wr_busy;
`ifdef WR_FRAME_CNT_EN
    logic [7:0]  wr_frame_cnt;
`endif

    wr_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ddr_init_done     (ddr_init_done),
        .wr_fifo_cnt       (wr_fifo_cnt),
        .wr_buffer_ready   (wr_buffer_ready),
        .wr_burst_done     (wr_burst_done),
        .wr_req_en         (wr_req_en),
        .wr_addr_out       (wr_addr_out),
        .wr_burst_length   (wr_burst_length),
        .user_wr_mode      (user_wr_mode),
        .user_wr_req       (user_wr_req),
        .user_wr_addr      (user_wr_addr),
        .user_wr_length    (user_wr_length),
        .user_wr_base_addr (user_wr_base_addr),
        .user_wr_end_addr  (user_wr_end_addr),
        .user_wr_busy      (user_wr_busy)
`ifdef WR_FRAME_CNT_EN
        ,
        .wr_frame_cnt      (wr_frame_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input int budget, output bit found, output int cycles);
        found  = 1'b0;
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (wr_req_en) begin
                found  = 1'b1;
                cycles = i;
                break;
            end
        end
    endtask

    task automatic pulse_done();
        wr_burst_done = 1'b1;
        @(negedge clk);
        wr_burst_done = 1'b0;
    endtask

    task automatic user_edge(input logic [31:0] addr, input logic [12:0] len);
        user_wr_addr   = addr;
        user_wr_length = len;
        user_wr_req    = 1'b1;
        tick(4);
        user_wr_req    = 1'b0;
        tick(3);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [12:0] len;
        logic [9:0]  fifo;
        bit          issue;
        logic [7:0]  exp_len;
    } single_vec_t;

    single_vec_t vecs[6];
    logic [31:0] ring_exp[5];

    initial begin
        bit found;
        int cyc;
        int bad;

        vecs[0] = '{32'h0000_8000, 13'd1024, 10'd64,  1'b1, 8'd63};
        vecs[1] = '{32'h0000_1230, 13'd16,   10'd1,   1'b1, 8'd0};
        vecs[2] = '{32'h0000_2000, 13'd4096, 10'd256, 1'b1, 8'd255};
        vecs[3] = '{32'h0000_3000, 13'd4112, 10'd256, 1'b1, 8'd255};
        vecs[4] = '{32'h0000_4000, 13'd8,    10'd100, 1'b0, 8'd0};
        vecs[5] = '{32'h0000_5000, 13'd100,  10'd6,   1'b1, 8'd5};
        ring_exp[0] = 32'h0000_0000;
        ring_exp[1] = 32'h0000_1000;
        ring_exp[2] = 32'h0000_2000;
        ring_exp[3] = 32'h0000_3000;
        ring_exp[4] = 32'h0000_0000;

        reset_n           = 1'b1;
        ddr_init_done     = 1'b1;
        wr_fifo_cnt       = '0;
        wr_buffer_ready   = 1'b0;
        wr_burst_done     = 1'b0;
        user_wr_mode      = 1'b0;
        user_wr_req       = 1'b0;
        user_wr_addr      = '0;
        user_wr_length    = '0;
        user_wr_base_addr = 32'h0000_0000;
        user_wr_end_addr  = 32'h0000_4000;

        #2 reset_n = 1'b0;
        tick(2);
        check("rst_req_en", wr_req_en, 1'b0);
        check("rst_addr", wr_addr_out, 32'h0);
        check("rst_len", wr_burst_length, 8'd0);
        check("rst_busy", user_wr_busy, 1'b0);
        reset_n = 1'b1;
        tick(10);

        // Ring walk across a four-burst window with wrap
        wr_buffer_ready = 1'b1;
        wr_fifo_cnt     = 10'd256;
        for (int i = 0; i < 5; i++) begin
            wait_req(30, found, cyc);
            check("ring_req_seen", found, 1'b1);
            check("ring_addr", wr_addr_out, ring_exp[i]);
            check("ring_len", wr_burst_length, 8'd255);
            tick(1);
            if (i == 4) wr_fifo_cnt = '0;
            check("ring_req_drop", wr_req_en, 1'b0);
            tick(19);
            pulse_done();
        end
        tick(2);
`ifdef WR_FRAME_CNT_EN
        check("ring_frame_cnt", wr_frame_cnt, 8'd1);
`endif

        // Stray done and ready while idle are ignored
        pulse_done();
        tick(3);
        check("idle_ignore_busy", user_wr_busy, 1'b0);
        check("idle_ignore_req", wr_req_en, 1'b0);
        wr_buffer_ready = 1'b0;

        // Fill level one below a burst, then exactly one burst
        wr_fifo_cnt = 10'd255;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (wr_req_en) bad++;
        end
        check("fifo255_no_req", bad, 0);
        wr_fifo_cnt = 10'd256;
        wait_req(3, found, cyc);
        check("fifo256_req_within3", found, 1'b1);
        check("fifo256_addr", wr_addr_out, 32'h0000_1000);

        // Stall with ready low: outputs hold
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (wr_req_en !== 1'b1 || wr_addr_out !== 32'h0000_1000 || wr_burst_length !== 8'd255) bad++;
        end
        check("stall_stable_cycles_bad", bad, 0);
        wr_buffer_ready = 1'b1;
        tick(1);
        wr_buffer_ready = 1'b0;
        check("stall_hs_req_drop", wr_req_en, 1'b0);
        check("stall_hs_addr_next", wr_addr_out, 32'h0000_2000);

        // Single request raised while the ring burst is in WAIT
        user_wr_mode = 1'b1;
        wr_fifo_cnt  = 10'd16;
        user_edge(32'h0000_9000, 13'd256);
        tick(3);
        check("wait_edge_no_req", wr_req_en, 1'b0);
        check("wait_edge_busy", user_wr_busy, 1'b1);
        pulse_done();
        wait_req(6, found, cyc);
        check("wait_edge_req_after_end", found, 1'b1);
        check("wait_edge_addr", wr_addr_out, 32'h0000_9000);
        check("wait_edge_len", wr_burst_length, 8'd15);
        wr_buffer_ready = 1'b1;
        tick(1);
        wr_buffer_ready = 1'b0;
        tick(3);
        pulse_done();
        tick(1);
        check("wait_edge_idle_busy", user_wr_busy, 1'b0);

        // Single-mode request table
        for (int v = 0; v < 6; v++) begin
            user_wr_mode    = 1'b1;
            wr_buffer_ready = 1'b0;
            wr_fifo_cnt     = vecs[v].fifo;
            user_edge(vecs[v].addr, vecs[v].len);
            wait_req(8, found, cyc);
            check($sformatf("vec%0d_issue", v), found, vecs[v].issue);
            if (vecs[v].issue) begin
                check($sformatf("vec%0d_addr", v), wr_addr_out, vecs[v].addr);
                check($sformatf("vec%0d_len", v), wr_burst_length, vecs[v].exp_len);
                wr_buffer_ready = 1'b1;
                tick(1);
                wr_buffer_ready = 1'b0;
                check($sformatf("vec%0d_hs_drop", v), wr_req_en, 1'b0);
                tick(3);
                pulse_done();
                check($sformatf("vec%0d_end_busy", v), user_wr_busy, 1'b1);
                tick(1);
                check($sformatf("vec%0d_idle_busy", v), user_wr_busy, 1'b0);
            end else begin
                check($sformatf("vec%0d_cleared_busy", v), user_wr_busy, 1'b0);
            end
        end

        // Pending request starved of data, then overwritten by a second edge
        wr_fifo_cnt = '0;
        user_edge(32'h0000_A000, 13'd1024);
        tick(2);
        check("pend_starved_busy", user_wr_busy, 1'b1);
        check("pend_starved_no_req", wr_req_en, 1'b0);
        user_edge(32'h0000_B000, 13'd512);
        wr_fifo_cnt = 10'd32;
        wait_req(8, found, cyc);
        check("pend_over_req", found, 1'b1);
        check("pend_over_addr", wr_addr_out, 32'h0000_B000);
        check("pend_over_len", wr_burst_length, 8'd31);
        wr_buffer_ready = 1'b1;
        tick(1);
        wr_buffer_ready = 1'b0;
        tick(2);
        pulse_done();
        wr_fifo_cnt = 10'd100;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (wr_req_en) bad++;
        end
        check("pend_over_single_only", bad, 0);
        check("pend_over_idle_busy", user_wr_busy, 1'b0);

        // Init gating with a full buffer in ring mode
        user_wr_mode  = 1'b0;
        wr_fifo_cnt   = '0;
        ddr_init_done = 1'b0;
        tick(5);
        wr_fifo_cnt = 10'd512;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (wr_req_en) bad++;
        end
        check("init_low_no_req", bad, 0);
        ddr_init_done = 1'b1;
        wait_req(10, found, cyc);
        check("init_rise_req", found, 1'b1);
        check("init_rise_latency", cyc, 5);
        wr_buffer_ready = 1'b1;
        tick(1);
        wr_buffer_ready = 1'b0;
        ddr_init_done   = 1'b0;
        tick(6);
        check("init_drop_midburst_busy", user_wr_busy, 1'b1);
        pulse_done();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (wr_req_en) bad++;
        end
        check("init_drop_blocks_req", bad, 0);
        check("init_drop_idle_busy", user_wr_busy, 1'b0);
        ddr_init_done = 1'b1;
        wait_req(10, found, cyc);
        check("init_restore_req", found, 1'b1);
        wr_buffer_ready = 1'b1;
        tick(1);
        wr_buffer_ready = 1'b0;
        check("pre_reset_wait_busy", user_wr_busy, 1'b1);

        // Asynchronous reset during WAIT
        user_wr_base_addr = 32'h0001_0000;
        user_wr_end_addr  = 32'h0001_2000;
        #2 reset_n = 1'b0;
        #1;
        check("arst_req_en", wr_req_en, 1'b0);
        check("arst_addr", wr_addr_out, 32'h0001_0000);
        check("arst_len", wr_burst_length, 8'd0);
        check("arst_busy", user_wr_busy, 1'b0);
`ifdef WR_FRAME_CNT_EN
        check("arst_frame_cnt", wr_frame_cnt, 8'd0);
`endif
        tick(3);
        reset_n = 1'b1;
        wait_req(25, found, cyc);
        check("post_reset_req", found, 1'b1);
        check("post_reset_addr", wr_addr_out, 32'h0001_0000);
        check("post_reset_len", wr_burst_length, 8'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
